valu_ctrl: RTL and testbench

VALU_CTRL -- requirements
Module: valu_ctrl

---
 rtl/valu_ctrl.sv | 157 +++++++++++++++
 tb/tb_valu_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_ctrl.sv
// VALU sequencer: splits a vector instruction into LANE-element slices,
// issuing one VRF read and one VALU/write-back step per slice.
package valu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_MIN, ALU_MAX, ALU_SLL,
      ALU_SRL, ALU_SRA, ALU_MSEQ, ALU_MSLT
   } type_scr1_vop_alu_cmd_e;
endpackage

module valu_ctrl
   import valu_pkg::*;
#(
   parameter int LANE  = 8,
   parameter int VLMAX = 64,
   localparam int VW   = $clog2(VLMAX) + 1,
   localparam int KW   = $clog2(VLMAX / LANE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  type_scr1_vop_alu_cmd_e req_cmd,
   input  logic [4:0]             req_vd,
   input  logic [4:0]             req_vs1,
   input  logic [4:0]             req_vs2,
   input  logic                   req_vm,
   input  logic [VW-1:0]          req_vl,
   output logic                   vrf_rd_en,
   output logic [4:0]             vrf_rd_addr1,
   output logic [4:0]             vrf_rd_addr2,
   output logic [KW-1:0]          vrf_rd_chunk,
   output logic                   valu_enable,
   output logic                   valu_write_enable,
   output logic                   valu_maskreg_enable,
   output logic                   valu_mask,
   output type_scr1_vop_alu_cmd_e valu_cmd,
   output logic [31:0]            valu_vl,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [4:0]             wb_addr,
   output logic [KW-1:0]          wb_chunk,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_FIN} state_e;

   state_e                 state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   type_scr1_vop_alu_cmd_e cmd_q, cmd_d;
   logic [4:0]             vd_q, vd_d;
   logic [4:0]             vs1_q, vs1_d;
   logic [4:0]             vs2_q, vs2_d;
   logic                   vm_q, vm_d;
   logic [VW-1:0]          vl_q, vl_d;

   logic [31:0]            rem;
   logic                   last_slice;

   // Elements left from the current slice on, and whether it is the final one
   always_comb begin
      rem        = 32'(vl_q) - (32'(LANE) * 32'(k_q));
      last_slice = (32'(LANE) * (32'(k_q) + 32'd1)) >= 32'(vl_q);
   end

   // State and latched-instruction registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cmd_q   <= ALU_ADD;
         vd_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vm_q    <= 1'b0;
         vl_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cmd_q   <= cmd_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         vm_q    <= vm_d;
         vl_q    <= vl_d;
      end
   end

   // Next-state: accept in IDLE, alternate RD/EX per slice, then FIN
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cmd_d   = cmd_q;
      vd_d    = vd_q;
      vs1_d   = vs1_q;
      vs2_d   = vs2_q;
      vm_d    = vm_q;
      vl_d    = vl_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               cmd_d = req_cmd;
               vd_d  = req_vd;
               vs1_d = req_vs1;
               vs2_d = req_vs2;
               vm_d  = req_vm;
               k_d   = '0;
               vl_d  = (req_vl > VW'(VLMAX)) ? VW'(VLMAX) : req_vl;
               state_d = (req_vl == '0) ? S_FIN : S_RD;
            end
         end
         S_RD: state_d = S_EX;
         S_EX: begin
            if (wb_ready) begin
               if (last_slice) begin
                  state_d = S_FIN;
               end else begin
                  k_d     = k_q + KW'(1);
                  state_d = S_RD;
               end
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-state outputs; control strobes only asserted in their own state
   always_comb begin
      req_ready           = (state_q == S_IDLE);
      busy                = (state_q != S_IDLE);
      done                = (state_q == S_FIN);
      vrf_rd_en           = (state_q == S_RD);
      vrf_rd_addr1        = vs1_q;
      vrf_rd_addr2        = vs2_q;
      vrf_rd_chunk        = k_q;
      valu_enable         = 1'b0;
      valu_write_enable   = 1'b0;
      valu_maskreg_enable = 1'b0;
      valu_mask           = 1'b0;
      valu_cmd            = cmd_q;
      valu_vl             = '0;
      wb_valid            = 1'b0;
      wb_addr             = vd_q;
      wb_chunk            = k_q;
      if (state_q == S_EX) begin
         valu_enable         = 1'b1;
         valu_write_enable   = 1'b1;
         wb_valid            = 1'b1;
         valu_maskreg_enable = vm_q;
         valu_mask           = vm_q;
         valu_vl             = (rem > 32'(LANE)) ? 32'(LANE) : rem;
      end
   end

endmodule

// File: tb/tb_valu_ctrl.sv
// Testbench for valu_ctrl: vector table plus reset/stall sequences,
// with a read/write-back scoreboard.
module tb_valu_ctrl;
   import valu_pkg::*;

   localparam int LANE  = 8;
   localparam int VLMAX = 64;

   logic                   clk;
   logic                   rst;
   logic                   req_valid;
   logic                   req_ready;
   type_scr1_vop_alu_cmd_e req_cmd;
   logic [4:0]             req_vd, req_vs1, req_vs2;
   logic                   req_vm;
   logic [6:0]             req_vl;
   logic                   vrf_rd_en;
   logic [4:0]             vrf_rd_addr1, vrf_rd_addr2;
   logic [2:0]             vrf_rd_chunk;
   logic                   valu_enable, valu_write_enable;
   logic                   valu_maskreg_enable, valu_mask;
   type_scr1_vop_alu_cmd_e valu_cmd;
   logic [31:0]            valu_vl;
   logic                   wb_valid, wb_ready;
   logic [4:0]             wb_addr;
   logic [2:0]             wb_chunk;
   logic                   busy, done;

   valu_ctrl #(.LANE(LANE), .VLMAX(VLMAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_vd(req_vd),
      .req_vs1(req_vs1), .req_vs2(req_vs2),
      .req_vm(req_vm), .req_vl(req_vl),
      .vrf_rd_en(vrf_rd_en),
      .vrf_rd_addr1(vrf_rd_addr1), .vrf_rd_addr2(vrf_rd_addr2),
      .vrf_rd_chunk(vrf_rd_chunk),
      .valu_enable(valu_enable),
      .valu_write_enable(valu_write_enable),
      .valu_maskreg_enable(valu_maskreg_enable),
      .valu_mask(valu_mask), .valu_cmd(valu_cmd),
      .valu_vl(valu_vl),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_chunk(wb_chunk),
      .busy(busy), .done(done)
   );

   typedef struct {
      type_scr1_vop_alu_cmd_e cmd;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic       vm;
      logic [6:0] vl;
      int         stall;
      int         lat;
   } vec_t;

   typedef struct {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [2:0] chunk;
   } rd_t;

   typedef struct {
      logic [4:0]  addr;
      logic [2:0]  chunk;
      logic [31:0] vl;
      logic        vm;
      type_scr1_vop_alu_cmd_e cmd;
   } wb_t;

   rd_t  rdq[$];
   wb_t  wbq[$];
   vec_t vecs[9];

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Expected read and write-back slices for one instruction
   task automatic expect_op(input vec_t v, input int max_rd,
                            input int max_wb);
      int eff;
      int n;
      int len;
      eff = (v.vl > 7'd64) ? 64 : int'(v.vl);
      n   = (eff + LANE - 1) / LANE;
      for (int c = 0; c < n; c++) begin
         len = eff - LANE * c;
         if (len > LANE) len = LANE;
         if (c < max_rd) rdq.push_back('{v.vs1, v.vs2, 3'(c)});
         if (c < max_wb)
            wbq.push_back('{v.vd, 3'(c), 32'(len), v.vm, v.cmd});
      end
   endtask

   // Scoreboard monitor, sampled after the falling edge
   always begin
      rd_t r;
      wb_t w;
      @(negedge clk);
      #1;
      if (!rst) begin
         chk("busy_inv", 64'(busy), 64'(!req_ready));
         chk("en_inv", 64'({valu_enable, valu_write_enable}),
             64'({wb_valid, wb_valid}));
         chk("rd_wb_excl", 64'(vrf_rd_en & wb_valid), 64'(0));
         if (vrf_rd_en) begin
            if (rdq.size() == 0) begin
               chk("rd_unexpected", 64'(1), 64'(0));
            end else begin
               r = rdq.pop_front();
               chk("rd_addr1", 64'(vrf_rd_addr1), 64'(r.a1));
               chk("rd_addr2", 64'(vrf_rd_addr2), 64'(r.a2));
               chk("rd_chunk", 64'(vrf_rd_chunk), 64'(r.chunk));
            end
         end
         if (wb_valid && wb_ready) begin
            if (wbq.size() == 0) begin
               chk("wb_unexpected", 64'(1), 64'(0));
            end else begin
               w = wbq.pop_front();
               chk("wb_addr", 64'(wb_addr), 64'(w.addr));
               chk("wb_chunk", 64'(wb_chunk), 64'(w.chunk));
               chk("valu_vl", 64'(valu_vl), 64'(w.vl));
               chk("valu_mask", 64'(valu_mask), 64'(w.vm));
               chk("maskreg_en", 64'(valu_maskreg_enable), 64'(w.vm));
               chk("valu_cmd", 64'(valu_cmd), 64'(w.cmd));
            end
         end
      end
   end

   task automatic drive_req(input vec_t v);
      req_valid = 1'b1;
      req_cmd   = v.cmd;
      req_vd    = v.vd;
      req_vs1   = v.vs1;
      req_vs2   = v.vs2;
      req_vm    = v.vm;
      req_vl    = v.vl;
      chk("req_ready", 64'(req_ready), 64'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_vd    = ~v.vd;
      req_vs1   = ~v.vs1;
      req_vs2   = ~v.vs2;
      req_vm    = ~v.vm;
      req_vl    = 7'd5;
      req_cmd   = ALU_XOR;
   endtask

   function automatic logic [63:0] snap_out();
      return {14'd0, wb_addr, wb_chunk, valu_vl, valu_mask,
              valu_maskreg_enable, valu_cmd, wb_valid, valu_enable,
              valu_write_enable, vrf_rd_en};
   endfunction

   // Runs one instruction from an IDLE falling edge; returns at the
   // falling edge after done, with the FSM back in IDLE
   task automatic run_op(input vec_t v);
      int          cyc;
      int          stall_left;
      bit          got;
      bit          snapped;
      logic [63:0] snap;
      expect_op(v, 99, 99);
      drive_req(v);
      cyc        = 0;
      got        = 0;
      snapped    = 0;
      snap       = '0;
      stall_left = v.stall;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (wb_valid && stall_left > 0) begin
            if (!snapped) begin
               snap    = snap_out();
               snapped = 1;
            end else begin
               chk("stall_hold", snap_out(), snap);
            end
            wb_ready = 1'b0;
            stall_left--;
         end else begin
            if (wb_valid && snapped) begin
               chk("stall_hold", snap_out(), snap);
               snapped = 0;
            end
            wb_ready = 1'b1;
         end
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("latency", got ? 64'(cyc) : 64'(999), 64'(v.lat));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("idle_after_fin", 64'(req_ready), 64'(1));
      chk("rdq_drained", 64'(rdq.size()), 64'(0));
      chk("wbq_drained", 64'(wbq.size()), 64'(0));
      rdq.delete();
      wbq.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 64'(req_ready), 64'(1));
      chk({tag, "_ones"}, 64'({busy, done, vrf_rd_en, valu_enable,
          valu_write_enable, valu_maskreg_enable, valu_mask, wb_valid}),
          64'(0));
      chk({tag, "_vals"}, 64'({valu_vl, wb_addr, wb_chunk,
          vrf_rd_addr1, vrf_rd_addr2, vrf_rd_chunk}), 64'(0));
   endtask

   initial begin
      vec_t v;
      int   nwb;
      int   cyc;
      bit   saw_done;

      vecs[0] = '{ALU_ADD,  5'd3,  5'd1,  5'd2,  1'b0, 7'd20,  0, 7};
      vecs[1] = '{ALU_SUB,  5'd9,  5'd4,  5'd5,  1'b0, 7'd0,   0, 1};
      vecs[2] = '{ALU_AND,  5'd10, 5'd11, 5'd12, 1'b0, 7'd16,  3, 8};
      vecs[3] = '{ALU_OR,   5'd31, 5'd30, 5'd29, 1'b1, 7'd64,  0, 17};
      vecs[4] = '{ALU_XOR,  5'd6,  5'd7,  5'd8,  1'b0, 7'd100, 0, 17};
      vecs[5] = '{ALU_MIN,  5'd1,  5'd2,  5'd3,  1'b1, 7'd8,   0, 3};
      vecs[6] = '{ALU_MAX,  5'd17, 5'd18, 5'd19, 1'b0, 7'd1,   0, 3};
      vecs[7] = '{ALU_SLL,  5'd20, 5'd21, 5'd22, 1'b1, 7'd63,  0, 17};
      vecs[8] = '{ALU_SRA,  5'd13, 5'd14, 5'd15, 1'b0, 7'd9,   1, 6};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = ALU_MSLT;
      req_vd    = 5'd0;
      req_vs1   = 5'd0;
      req_vs2   = 5'd0;
      req_vm    = 1'b0;
      req_vl    = 7'd0;
      wb_ready  = 1'b1;

      @(negedge clk);
      chk_reset_outputs("rst_init");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_op(vecs[i]);

      // Reset in the second EX of a vl=24 instruction
      v = '{ALU_ADD, 5'd25, 5'd26, 5'd27, 1'b1, 7'd24, 0, 0};
      expect_op(v, 2, 1);
      drive_req(v);
      nwb      = 0;
      cyc      = 0;
      saw_done = 0;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (done) saw_done = 1;
         if (wb_valid) nwb++;
         if (nwb == 2) break;
      end
      chk("rst_reach_ex2", 64'(nwb), 64'(2));
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done || wb_valid) saw_done = 1;
         chk_reset_outputs("rst_hold");
      end
      chk("rst_no_done", 64'(saw_done), 64'(0));
      chk("rst_rdq", 64'(rdq.size()), 64'(0));
      chk("rst_wbq", 64'(wbq.size()), 64'(0));
      rdq.delete();
      wbq.delete();
      rst = 1'b0;

      v = '{ALU_SRL, 5'd2, 5'd3, 5'd4, 1'b0, 7'd8, 0, 3};
      run_op(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $fatal(1);
   end

endmodule
